// File: rtl/rvvi_host_ack_rx.sv
// RVVI host-ack receiver: parses host reply frames, tracks trace backlog, paces the core.
// Optional macro RVVI_ACK_LOAD_THROTTLE_EN adds a host-load term to ExternalStall.
module rvvi_host_ack_rx #(
    parameter logic [15:0] ETHER_TYPE      = 16'h005C,
    parameter logic [63:0] MAX_OUTSTANDING = 64'd256,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd100000
`ifdef RVVI_ACK_LOAD_THROTTLE_EN
   ,parameter logic [31:0] LOAD_THRESHOLD  = 32'h0000_8000
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SentValid,
    input  logic [63:0] SentMinstret,
    input  logic [31:0] RxData,
    input  logic [3:0]  RxKeep,
    input  logic        RxValid,
    input  logic        RxLast,
    output logic        RxReady,
    output logic        AckValid,
    output logic [63:0] AckedMinstret,
    output logic [31:0] HostLoad,
    output logic        ExternalStall,
    output logic        Timeout,
    output logic [15:0] BadFrameCount
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HDR     = 3'd1;
    localparam logic [2:0] PAYLOAD = 3'd2;
    localparam logic [2:0] DRAIN   = 3'd3;
    localparam logic [2:0] COMMIT  = 3'd4;

    logic [2:0]  state;
    logic [2:0]  wordIdx;
    logic [2:0]  curIdx;
    logic        wordErr;
    logic        accept;
    logic        commitTake;
    logic [63:0] lastSent;
    logic [63:0] outstanding;
    logic [31:0] toCnt;
    logic [15:0] shAckLo;
    logic [31:0] shAckMid;
    logic [15:0] shAckHi;
    logic [31:0] shLoad;
    logic [63:0] shadowAck;

    assign accept     = RxValid & RxReady;
    assign shadowAck  = {shAckHi, shAckMid, shAckLo};
    assign commitTake = (state == COMMIT) && (shadowAck >= AckedMinstret);

    // A word seen in IDLE or COMMIT is always w0 of a fresh frame.
    always_comb begin
        curIdx  = (state == HDR || state == PAYLOAD) ? wordIdx : 3'd0;
        wordErr = (RxKeep != 4'hF)
                || (RxLast && curIdx != 3'd6)
                || (!RxLast && curIdx == 3'd6)
                || (curIdx == 3'd3 && RxData[15:0] != ETHER_TYPE);
    end

    always_comb begin
        outstanding = '0;
        if (lastSent >= AckedMinstret)
            outstanding = lastSent - AckedMinstret;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wordIdx       <= '0;
            RxReady       <= 1'b0;
            BadFrameCount <= '0;
        end else begin
            RxReady <= 1'b1;
            if (state == DRAIN) begin
                if (accept && RxLast)
                    state <= IDLE;
            end else if (accept) begin
                if (wordErr) begin
                    if (BadFrameCount != 16'hFFFF)
                        BadFrameCount <= BadFrameCount + 16'd1;
                    state <= RxLast ? IDLE : DRAIN;
                end else if (curIdx == 3'd6) begin
                    state <= COMMIT;
                end else begin
                    state   <= (curIdx >= 3'd2) ? PAYLOAD : HDR;
                    wordIdx <= curIdx + 3'd1;
                end
            end else if (state == COMMIT) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && state != DRAIN) begin
            case (curIdx)
                3'd3: shAckLo <= RxData[31:16];
                3'd4: shAckMid <= RxData;
                3'd5: begin
                    shAckHi      <= RxData[15:0];
                    shLoad[15:0] <= RxData[31:16];
                end
                3'd6: shLoad[31:16] <= RxData[15:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            AckedMinstret <= '0;
            HostLoad      <= '0;
            AckValid      <= 1'b0;
            lastSent      <= '0;
            ExternalStall <= 1'b0;
            toCnt         <= '0;
            Timeout       <= 1'b0;
        end else begin
            AckValid <= commitTake;
            Timeout  <= 1'b0;
            if (commitTake) begin
                AckedMinstret <= shadowAck;
                HostLoad      <= shLoad;
            end
            if (SentValid)
                lastSent <= SentMinstret;
`ifdef RVVI_ACK_LOAD_THROTTLE_EN
            ExternalStall <= (outstanding > MAX_OUTSTANDING) || (HostLoad > LOAD_THRESHOLD);
`else
            ExternalStall <= (outstanding > MAX_OUTSTANDING);
`endif
            if (outstanding == '0 || commitTake) begin
                toCnt <= '0;
            end else if (toCnt == TIMEOUT_CYCLES - 32'd1) begin
                Timeout <= 1'b1;
                toCnt   <= '0;
            end else begin
                toCnt <= toCnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_rvvi_host_ack_rx.sv
// Directed bench for rvvi_host_ack_rx with hand-computed expectations.
module tb_rvvi_host_ack_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        SentValid;
    logic [63:0] SentMinstret;
    logic [31:0] RxData;
    logic [3:0]  RxKeep;
    logic        RxValid;
    logic        RxLast;
    logic        RxReady;
    logic        AckValid;
    logic [63:0] AckedMinstret;
    logic [31:0] HostLoad;
    logic        ExternalStall;
    logic        Timeout;
    logic [15:0] BadFrameCount;

    int tests = 0;
    int fails = 0;
    int ackCount = 0;
    int toCount = 0;
    int cyc = 0;
    int toStamp[$];

    rvvi_host_ack_rx #(.TIMEOUT_CYCLES(32'd10)) dut (
        .clk(clk), .reset(reset),
        .SentValid(SentValid), .SentMinstret(SentMinstret),
        .RxData(RxData), .RxKeep(RxKeep), .RxValid(RxValid), .RxLast(RxLast),
        .RxReady(RxReady), .AckValid(AckValid), .AckedMinstret(AckedMinstret),
        .HostLoad(HostLoad), .ExternalStall(ExternalStall), .Timeout(Timeout),
        .BadFrameCount(BadFrameCount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (AckValid === 1'b1) ackCount++;
        if (Timeout === 1'b1) begin
            toCount++;
            toStamp.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        RxValid = 1'b0;
        RxLast  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic doReset();
        RxValid = 1'b0; RxLast = 1'b0; SentValid = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic sendWord(input logic [31:0] d, input logic [3:0] k, input logic l);
        RxData = d; RxKeep = k; RxLast = l; RxValid = 1'b1;
        tick();
    endtask

    task automatic sendGood(input logic [63:0] ack, input logic [31:0] load);
        sendWord(32'hAAAA_0000, 4'hF, 1'b0);
        sendWord(32'hAAAA_0001, 4'hF, 1'b0);
        sendWord(32'hAAAA_0002, 4'hF, 1'b0);
        sendWord({ack[15:0], 16'h005C}, 4'hF, 1'b0);
        sendWord(ack[47:16], 4'hF, 1'b0);
        sendWord({load[15:0], ack[63:48]}, 4'hF, 1'b0);
        sendWord({16'hBEEF, load[31:16]}, 4'hF, 1'b1);
    endtask

    // Generic frame: n words, RxLast on lastAt, keep 4'h7 on badKeepAt, EtherType et.
    task automatic sendFrame(input int n, input int lastAt, input int badKeepAt, input logic [15:0] et);
        for (int i = 0; i < n; i++)
            sendWord((i == 3) ? {16'h0000, et} : 32'h0,
                     (i == badKeepAt) ? 4'h7 : 4'hF, i == lastAt);
    endtask

    task automatic pulseSent(input logic [63:0] v);
        SentMinstret = v; SentValid = 1'b1;
        tick();
        SentValid = 1'b0;
    endtask

    int base;

    initial begin
        reset = 1'b1; SentValid = 1'b0; SentMinstret = '0;
        RxData = '0; RxKeep = '0; RxValid = 1'b0; RxLast = 1'b0;

        // Reset values
        tick(); tick();
        checkEq("rst_rxready", RxReady, 0);
        checkEq("rst_ackvalid", AckValid, 0);
        checkEq("rst_acked", AckedMinstret, 0);
        checkEq("rst_hostload", HostLoad, 0);
        checkEq("rst_stall", ExternalStall, 0);
        checkEq("rst_timeout", Timeout, 0);
        checkEq("rst_bad", BadFrameCount, 0);
        reset = 1'b0;
        tick();
        checkEq("rxready_after_rst", RxReady, 1);

        // Single good ack
        doReset();
        pulseSent(64'd100);
        base = ackCount;
        sendGood(64'd100, 32'd1);
        idle(3);
        checkEq("good_acked", AckedMinstret, 100);
        checkEq("good_load", HostLoad, 1);
        checkEq("good_pulses", ackCount - base, 1);
        checkEq("good_stall", ExternalStall, 0);

        // Backlog stall, latency and threshold boundary
        doReset();
        pulseSent(64'd300);
        checkEq("stall_latency", ExternalStall, 0);
        tick();
        checkEq("stall_300", ExternalStall, 1);
        sendGood(64'd100, 32'd0);
        idle(3);
        checkEq("stall_after_ack100", ExternalStall, 0);
        pulseSent(64'd357);
        tick();
        checkEq("stall_257", ExternalStall, 1);
        pulseSent(64'd356);
        tick();
        checkEq("stall_256", ExternalStall, 0);
        sendGood(64'd300, 32'd0);
        idle(3);
        checkEq("stall_after_ack300", ExternalStall, 0);

        // Ack beyond LastSent clamps backlog to zero
        doReset();
        sendGood(64'd1000, 32'd0);
        idle(3);
        base = toCount;
        idle(30);
        checkEq("clamp_stall", ExternalStall, 0);
        checkEq("clamp_no_timeout", toCount - base, 0);

        // Bad frames
        doReset();
        sendGood(64'd40, 32'd0);
        idle(3);
        base = ackCount;
        sendFrame(7, 6, -1, 16'h0800); idle(2);
        sendFrame(5, 4, -1, 16'h005C); idle(2);
        sendFrame(9, 8, -1, 16'h005C); idle(2);
        sendFrame(7, 6, 2, 16'h005C);  idle(2);
        sendFrame(1, 0, -1, 16'h005C); idle(3);
        checkEq("bad_count", BadFrameCount, 5);
        checkEq("bad_acked", AckedMinstret, 40);
        checkEq("bad_no_pulse", ackCount - base, 0);
        sendGood(64'd60, 32'd0);
        idle(3);
        checkEq("bad_then_good", AckedMinstret, 60);

        // Stale ack back-to-back (second w0 lands in COMMIT)
        doReset();
        base = ackCount;
        sendGood(64'd500, 32'd3);
        sendGood(64'd300, 32'd4);
        idle(4);
        checkEq("stale_acked", AckedMinstret, 500);
        checkEq("stale_load", HostLoad, 3);
        checkEq("stale_pulses", ackCount - base, 1);
        base = ackCount;
        sendGood(64'd600, 32'd7);
        sendGood(64'd700, 32'd9);
        idle(4);
        checkEq("b2b_acked", AckedMinstret, 700);
        checkEq("b2b_load", HostLoad, 9);
        checkEq("b2b_pulses", ackCount - base, 2);
        checkEq("b2b_bad", BadFrameCount, 0);

        // Reset mid-frame discards the partial frame
        doReset();
        sendFrame(4, -1, -1, 16'h005C);
        doReset();
        sendGood(64'd77, 32'd3);
        idle(3);
        checkEq("midrst_acked", AckedMinstret, 77);
        checkEq("midrst_bad", BadFrameCount, 0);

        // Timeout with TIMEOUT_CYCLES=10
        doReset();
        base = toCount;
        toStamp.delete();
        pulseSent(64'd5);
        repeat (10) tick();
        checkEq("to_none_by_10", toCount - base, 0);
        tick();
        checkEq("to_first_at_11", toCount - base, 1);
        repeat (20) tick();
        checkEq("to_three", toCount - base, 3);
        if (toStamp.size() >= 3) begin
            checkEq("to_gap1", toStamp[1] - toStamp[0], 10);
            checkEq("to_gap2", toStamp[2] - toStamp[1], 10);
        end else begin
            checkEq("to_stamps", toStamp.size(), 3);
        end
        sendGood(64'd5, 32'd0);
        idle(3);
        base = toCount;
        idle(30);
        checkEq("to_stopped", toCount - base, 0);
        checkEq("to_stall", ExternalStall, 0);

        // Host-load throttle term
        doReset();
        sendGood(64'd0, 32'h0001_0000);
        idle(3);
        checkEq("load_captured", HostLoad, 32'h0001_0000);
`ifdef RVVI_ACK_LOAD_THROTTLE_EN
        checkEq("load_stall", ExternalStall, 1);
`else
        checkEq("load_stall", ExternalStall, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
